// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified IF/MEM memory arbiter.
package mem_arb_pkg;

    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_DM = 1'b1
    } grant_e;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that times an access through the memory latency.
module mem_wait_counter
    import mem_arb_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one fixed-latency single-port memory between instruction fetch
// and data access, returning results to the winner and stalling the pipeline.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_pipe
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LATENCY - 1);

    state_e state_q, state_d;
    grant_e last_grant_q, last_grant_d;
    grant_e grant_q, grant_d;
    logic   we_q, we_d;
    grant_e issue_grant;
    logic   cnt_load;
    logic   cnt_dec;
    logic   cnt_zero;

    mem_wait_counter u_wait_counter (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (LOAD_VAL),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        we_d         = we_q;
        issue_grant  = GRANT_IF;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        if_ready     = 1'b0;
        if_rdata     = '0;
        dm_ready     = 1'b0;
        dm_rdata     = '0;
        case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    // Data wins a tie unless it also won the previous grant.
                    if (dm_req && (!if_req || (last_grant_q == GRANT_IF))) begin
                        issue_grant = GRANT_DM;
                    end
                    mem_en       = 1'b1;
                    cnt_load     = 1'b1;
                    state_d      = BUSY;
                    last_grant_d = issue_grant;
                    grant_d      = issue_grant;
                    if (issue_grant == GRANT_DM) begin
                        mem_addr  = dm_addr;
                        mem_we    = dm_we;
                        mem_wdata = dm_we ? dm_wdata : '0;
                        we_d      = dm_we;
                    end else begin
                        mem_addr = if_addr;
                        we_d     = 1'b0;
                    end
                end
            end
            BUSY: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    // A withdrawn requester gets no ready; the result is dropped.
                    state_d = IDLE;
                    if (grant_q == GRANT_DM) begin
                        dm_ready = dm_req;
                        dm_rdata = (dm_req && !we_q) ? mem_rdata : '0;
                    end else begin
                        if_ready = if_req;
                        if_rdata = if_req ? mem_rdata : '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_IF;
            grant_q      <= GRANT_IF;
            we_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
        end
    end

    assign stall_pipe = (if_req && !if_ready) || (dm_req && !dm_ready);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter at latencies 2, 1 and 15 against a transaction-level model.
module tb_unified_mem_arbiter;

    localparam int N    = 3;
    localparam int LAT0 = 2;
    localparam int LAT1 = 1;
    localparam int LAT2 = 15;

    int lat_t [N] = '{LAT0, LAT1, LAT2};

    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    logic        if_req    [N];
    logic [31:0] if_addr   [N];
    logic        dm_req    [N];
    logic        dm_we     [N];
    logic [31:0] dm_addr   [N];
    logic [31:0] dm_wdata  [N];
    logic        if_ready_w[N];
    logic [31:0] if_rdata_w[N];
    logic        dm_ready_w[N];
    logic [31:0] dm_rdata_w[N];
    logic        mem_en_w  [N];
    logic        mem_we_w  [N];
    logic [31:0] mem_addr_w[N];
    logic [31:0] mem_wdata_w[N];
    logic [31:0] mem_rdata_s[N];
    logic        stall_w   [N];

    int if_want[N];
    int dm_want[N];
    bit seen_ir[N];
    bit seen_dr[N];

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] init_word(int i);
        logic [7:0] b;
        b = i[7:0];
        if (i == 16) return 32'h8C22_0004;
        return {b, 8'hA5, ~b, 8'h3C};
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        a[1:0] = 2'b00;
        return a;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, act, exp);
        end
    endtask

    for (genvar g = 0; g < N; g++) begin : gi
        localparam int LAT = (g == 0) ? LAT0 : ((g == 1) ? LAT1 : LAT2);
        logic [31:0] rmem [256];
        logic [31:0] rd_val;
        logic [31:0] junk;
        int          rd_cyc;

        initial begin
            rd_cyc = -1;
            rd_val = '0;
            junk   = '0;
            for (int i = 0; i < 256; i++) rmem[i] = init_word(i);
        end

        unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT)) dut (
            .clock      (clock),
            .reset      (reset),
            .if_req     (if_req[g]),
            .if_addr    (if_addr[g]),
            .if_rdata   (if_rdata_w[g]),
            .if_ready   (if_ready_w[g]),
            .dm_req     (dm_req[g]),
            .dm_we      (dm_we[g]),
            .dm_addr    (dm_addr[g]),
            .dm_wdata   (dm_wdata[g]),
            .dm_rdata   (dm_rdata_w[g]),
            .dm_ready   (dm_ready_w[g]),
            .mem_en     (mem_en_w[g]),
            .mem_we     (mem_we_w[g]),
            .mem_addr   (mem_addr_w[g]),
            .mem_wdata  (mem_wdata_w[g]),
            .mem_rdata  (mem_rdata_s[g]),
            .stall_pipe (stall_w[g])
        );

        // Memory macro: read data is valid only LAT cycles after issue, junk otherwise.
        assign mem_rdata_s[g] = (cyc == rd_cyc) ? rd_val : junk;

        always @(posedge clock) begin
            junk <= $urandom;
            if (mem_en_w[g]) begin
                rd_cyc <= cyc + LAT;
                rd_val <= rmem[mem_addr_w[g][9:2]];
                if (mem_we_w[g]) rmem[mem_addr_w[g][9:2]] <= mem_wdata_w[g];
            end
        end
    end

    // Reference model: at most one access in flight, finishing LAT cycles after issue.
    logic [31:0] mmem [N][256];
    bit          m_busy   [N];
    int          m_done   [N];
    bit          m_dm     [N];
    bit          m_we     [N];
    bit          m_last_dm[N];
    logic [31:0] m_rd     [N];

    initial begin
        for (int g = 0; g < N; g++) begin
            m_busy[g] = 0; m_done[g] = 0; m_dm[g] = 0; m_we[g] = 0;
            m_last_dm[g] = 0; m_rd[g] = '0;
            for (int i = 0; i < 256; i++) mmem[g][i] = init_word(i);
        end
        forever begin
            @(negedge clock);
            for (int g = 0; g < N; g++) begin
                logic        e_en, e_we, e_ir, e_dr, e_st, gdm;
                logic [31:0] e_addr, e_wd, e_ird, e_drd;
                int          idx;
                string       p;
                e_en = 0; e_we = 0; e_ir = 0; e_dr = 0; gdm = 0;
                e_addr = '0; e_wd = '0; e_ird = '0; e_drd = '0;
                if (reset) begin
                    m_busy[g]    = 0;
                    m_last_dm[g] = 0;
                end else if (!m_busy[g]) begin
                    if (if_req[g] || dm_req[g]) begin
                        gdm  = dm_req[g] && (!if_req[g] || !m_last_dm[g]);
                        e_en = 1;
                        if (gdm) begin
                            e_addr = dm_addr[g];
                            e_we   = dm_we[g];
                            e_wd   = dm_we[g] ? dm_wdata[g] : '0;
                        end else begin
                            e_addr = if_addr[g];
                        end
                        idx = int'(e_addr[9:2]);
                        m_rd[g] = mmem[g][idx];
                        if (e_we) mmem[g][idx] = dm_wdata[g];
                        m_busy[g]    = 1;
                        m_done[g]    = cyc + lat_t[g];
                        m_dm[g]      = gdm;
                        m_we[g]      = e_we;
                        m_last_dm[g] = gdm;
                    end
                end else if (cyc == m_done[g]) begin
                    if (m_dm[g]) begin
                        e_dr  = dm_req[g];
                        e_drd = (dm_req[g] && !m_we[g]) ? m_rd[g] : '0;
                    end else begin
                        e_ir  = if_req[g];
                        e_ird = if_req[g] ? m_rd[g] : '0;
                    end
                    m_busy[g] = 0;
                end
                e_st = (if_req[g] && !e_ir) || (dm_req[g] && !e_dr);
                p = $sformatf("L%0d@%0d", lat_t[g], cyc);
                check_eq({p, " mem_en"},    64'(mem_en_w[g]),    64'(e_en));
                check_eq({p, " mem_we"},    64'(mem_we_w[g]),    64'(e_we));
                check_eq({p, " mem_addr"},  64'(mem_addr_w[g]),  64'(e_addr));
                check_eq({p, " mem_wdata"}, 64'(mem_wdata_w[g]), 64'(e_wd));
                check_eq({p, " if_ready"},  64'(if_ready_w[g]),  64'(e_ir));
                check_eq({p, " if_rdata"},  64'(if_rdata_w[g]),  64'(e_ird));
                check_eq({p, " dm_ready"},  64'(dm_ready_w[g]),  64'(e_dr));
                check_eq({p, " dm_rdata"},  64'(dm_rdata_w[g]),  64'(e_drd));
                check_eq({p, " stall"},     64'(stall_w[g]),     64'(e_st));
                seen_ir[g] = if_ready_w[g];
                seen_dr[g] = dm_ready_w[g];
            end
        end
    end

    // Requester behaviour: hold each request until ready, re-raising while work remains.
    task automatic drive_step(input bit rnd);
        for (int g = 0; g < N; g++) begin
            bit wd;
            if (seen_ir[g] && if_want[g] > 0) if_want[g]--;
            wd = 0;
            if (rnd && if_req[g] && !seen_ir[g] && ($urandom % 24) == 0) begin
                if_req[g] = 0;
                wd = 1;
                if (if_want[g] > 0) if_want[g]--;
            end
            if (!wd) begin
                if (if_want[g] == 0) if_req[g] = 0;
                else if (!if_req[g] || seen_ir[g]) begin
                    if_req[g]  = 1;
                    if_addr[g] = rand_addr();
                end
            end
            if (seen_dr[g] && dm_want[g] > 0) dm_want[g]--;
            wd = 0;
            if (rnd && dm_req[g] && !seen_dr[g] && ($urandom % 24) == 0) begin
                dm_req[g] = 0;
                wd = 1;
                if (dm_want[g] > 0) dm_want[g]--;
            end
            if (!wd) begin
                if (dm_want[g] == 0) dm_req[g] = 0;
                else if (!dm_req[g] || seen_dr[g]) begin
                    dm_req[g]   = 1;
                    dm_addr[g]  = rand_addr();
                    dm_we[g]    = rnd ? 1'($urandom % 2) : 1'b0;
                    dm_wdata[g] = $urandom;
                end
            end
            if (rnd) begin
                if (if_want[g] == 0 && ($urandom % 4) == 0) if_want[g] = 1 + int'($urandom % 3);
                if (dm_want[g] == 0 && ($urandom % 4) == 0) dm_want[g] = 1 + int'($urandom % 3);
            end
        end
    endtask

    function automatic bit pending();
        bit r;
        r = 0;
        for (int g = 0; g < N; g++)
            if (if_want[g] > 0 || dm_want[g] > 0 || if_req[g] || dm_req[g]) r = 1;
        return r;
    endfunction

    task automatic wait_quiet(input int maxc);
        int n;
        n = 0;
        while (pending() && n < maxc) begin
            @(posedge clock); #1;
            drive_step(0);
            n++;
        end
        check_eq("drain", 64'(pending()), 64'(0));
    endtask

    task automatic clear_inputs();
        for (int g = 0; g < N; g++) begin
            if_req[g] = 0; dm_req[g] = 0; dm_we[g] = 0;
            if_want[g] = 0; dm_want[g] = 0;
        end
    endtask

    task automatic apply_reset();
        @(posedge clock); #1;
        reset = 1;
        clear_inputs();
        repeat (2) @(posedge clock);
        #1 reset = 0;
    endtask

    task automatic set_fetch(input logic [31:0] a, input int want);
        for (int g = 0; g < N; g++) begin
            if_req[g] = 1; if_addr[g] = a; if_want[g] = want;
        end
    endtask

    task automatic set_data(input bit we, input logic [31:0] a, input logic [31:0] wd, input int want);
        for (int g = 0; g < N; g++) begin
            dm_req[g] = 1; dm_we[g] = we; dm_addr[g] = a; dm_wdata[g] = wd; dm_want[g] = want;
        end
    endtask

    initial begin
        reset = 1;
        for (int g = 0; g < N; g++) begin
            if_addr[g] = '0; dm_addr[g] = '0; dm_wdata[g] = '0;
            seen_ir[g] = 0; seen_dr[g] = 0;
        end
        clear_inputs();
        repeat (3) @(posedge clock);
        #1 reset = 0;

        // Lone fetch of the preloaded word at 0x40.
        set_fetch(32'h40, 1);
        wait_quiet(200);

        // Simultaneous load and fetch straight after reset: data first.
        apply_reset();
        set_data(0, 32'h100, 32'h0, 1);
        set_fetch(32'h44, 1);
        wait_quiet(200);

        // Both held across several accesses: grants alternate.
        @(posedge clock); #1;
        set_data(0, 32'h104, 32'h0, 3);
        set_fetch(32'h48, 3);
        wait_quiet(300);

        // Store.
        @(posedge clock); #1;
        set_data(1, 32'h20, 32'hDEAD_BEEF, 1);
        wait_quiet(200);

        // Fetch withdrawn one cycle after issue, then a new fetch to 0x80.
        @(posedge clock); #1;
        set_fetch(32'h40, 0);
        @(posedge clock); #1; drive_step(0);
        @(posedge clock); #1; drive_step(0);
        @(posedge clock); #1;
        set_fetch(32'h80, 1);
        wait_quiet(200);

        // Reset one cycle into a load, then a fresh fetch.
        @(posedge clock); #1;
        set_data(0, 32'h100, 32'h0, 1);
        apply_reset();
        set_fetch(32'h44, 1);
        wait_quiet(200);

        repeat (1500) begin
            @(posedge clock); #1;
            drive_step(1);
        end
        wait_quiet(400);
        repeat (20) @(posedge clock);
        @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
